systolic_result_drain: RTL and testbench
========================================

// Module: systolic_result_drain
// PURPOSE
//   Downstream stage of the systolic array top. Row i of the array presents its
//   partial sum i cycles after row 0, because DF is registered once per PE row.
//   This block deskews the row results into one aligned vector, accumulates
//   aligned vectors over a group, and buffers finished groups in a FIFO.
//   The FIFO drains over a valid/ready interface. The array cannot be stalled,
//   so FIFO overrun is flagged, never back-pressured.
// PARAMETERS
//   NUM_PE_ROWS     8   rows of the array = lanes of the result vector
//   PARTIAL_SUM_BW  19  width of each signed row result
//   ACC_BW          32  width of each signed accumulator lane; must be >= PARTIAL_SUM_BW
//   FIFO_DEPTH      4   finished-group entries; power of 2, >= 2
// PORTS
//   clk         in   1                        clock, rising edge
//   rst         in   1                        asynchronous, active-high reset
//   in_valid    in   1                        row 0 result valid this cycle (wave start)
//   in_last     in   1                        with in_valid: last vector of the group
//   result_flat in   NUM_PE_ROWS*PARTIAL_SUM_BW  row i at [i*PSB +: PSB], signed
//   out_data    out  NUM_PE_ROWS*ACC_BW       FIFO head; lane i at [i*ACC_BW +: ACC_BW]
//   out_valid   out  1                        FIFO not empty
//   out_ready   in   1                        consumer accepts out_data
//   fifo_count  out  $clog2(FIFO_DEPTH)+1     occupied entries
//   overflow    out  1                        sticky: a finished group was dropped
//   busy        out  1                        delay line, open group or FIFO non-empty
// BEHAVIOUR
// - Reset:
//   - Asynchronous; takes effect immediately.
//   - Clears delay lines, valid/last tags, accumulators, group-open flag, FIFO pointers and overflow.
//   - Outputs while rst=1: out_valid=0, fifo_count=0, overflow=0, busy=0, out_data=0.
//   - Reset mid-group discards all in-flight data. in_valid is ignored while rst=1.
// - Deskew:
//   - in_valid and in_last at cycle T tag the wave. Row i's sample is taken at cycle T+i.
//   - Row i passes through NUM_PE_ROWS-1-i registers; row NUM_PE_ROWS-1 has none.
//   - The tag passes through NUM_PE_ROWS-1 registers.
//   - The aligned vector and its tag are valid in cycle A = T+NUM_PE_ROWS-1.
//   - Back-to-back waves (in_valid every cycle) are supported; each wave is independent.
// - Accumulate (edge ending cycle A, only if aligned tag valid):
//   - Each lane is sign-extended to ACC_BW.
//   - sum_i = (group_open ? acc_i : 0) + ext(row_i). Two's-complement wrap, no saturation.
//   - last=0: acc <= sum; group_open <= 1.
//   - last=1: push sum into FIFO; group_open <= 0; acc unchanged (ignored on next open).
//   - A single wave with last=1 is a group of one.
// - FIFO:
//   - First-word fall-through. out_data = head entry; out_valid = (count!=0).
//   - Pop on out_valid && out_ready.
//   - Push when full and no pop in the same cycle: entry dropped, overflow <= 1 (stays until rst).
//   - Push and pop in the same cycle when full: both happen, count unchanged, no overflow.
//   - Push and pop in the same cycle when count=1: new entry becomes head, count stays 1.
//   - Pop when empty: impossible (out_valid=0); out_ready is ignored.
//   - Pointers wrap modulo FIFO_DEPTH.
//   - out_data must stay stable while out_valid=1 and out_ready=0.
// - Latency:
//   - in_valid+in_last at cycle T, FIFO empty -> out_valid=1 in cycle T+NUM_PE_ROWS.
//   - With defaults, T=0 -> out_valid in cycle 8.
// - busy:
//   - Combinational OR of: any delay-line tag valid, group_open, count!=0.
// TESTING (defaults unless noted)
// - Single group of one: in_valid=in_last=1 at cycle 0, row i=i+1 at cycle i
//   -> out_valid in cycle 8, lanes 1..8, fifo_count=1.
// - Group of 3: waves at cycles 0,1,2 (last on wave 2), every row = -5, -2, 100
//   -> one entry, all lanes 93; acc is not reused by the next group.
// - Width: every row = 2^18-1 (max positive 19-bit) for 16 waves, last on 16th
//   -> lanes 4194288, no wrap at ACC_BW=32.
// - Overflow: out_ready=0, 5 single-wave groups, FIFO_DEPTH=4
//   -> fifo_count=4, overflow=1, entries 1..4 intact;
//   then push+pop in the same cycle at full -> count 4, no loss.
// - Backpressure: 2 queued entries, toggle out_ready 1,0,1
//   -> out_data stable while ready=0, FIFO order preserved, count 2->1->1->0.
// - Reset mid-group: assert rst at cycle 4 of a 3-wave group
//   -> all outputs 0 at once; a new group after release sums from zero.

Source files
------------

// File: rtl/systolic_result_drain.sv
`default_nettype none
// ============================================================================
//  Module   : systolic_result_drain
//  Purpose  : Deskews staggered systolic row results into aligned vectors,
//             accumulates vectors over a group, and queues finished groups
//             in a first-word fall-through FIFO with a sticky overrun flag.
//  Revision : 1.0  initial release
// ============================================================================
module systolic_result_drain #(
   parameter int NUM_PE_ROWS    = 8,
   parameter int PARTIAL_SUM_BW = 19,
   parameter int ACC_BW         = 32,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  in_valid,
   input  logic                                  in_last,
   input  logic [NUM_PE_ROWS*PARTIAL_SUM_BW-1:0] result_flat,
   output logic [NUM_PE_ROWS*ACC_BW-1:0]         out_data,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic [$clog2(FIFO_DEPTH):0]           fifo_count,
   output logic                                  overflow,
   output logic                                  busy
);

   // Tag pipeline length equals the deepest row delay (row 0).
   localparam int DLY = NUM_PE_ROWS - 1;
   localparam int PSB = PARTIAL_SUM_BW;
   localparam int VW  = NUM_PE_ROWS * ACC_BW;
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int CW  = AW + 1;

   logic [DLY-1:0]             r_tag_v;
   logic [DLY-1:0]             r_tag_l;
   logic [NUM_PE_ROWS*PSB-1:0] w_aligned;
   logic [VW-1:0]              w_sum;
   logic [VW-1:0]              r_acc;
   logic                       r_open;
   logic [VW-1:0]              r_mem [FIFO_DEPTH];
   logic [AW-1:0]              r_wr;
   logic [AW-1:0]              r_rd;
   logic [CW-1:0]              r_count;
   logic                       r_overflow;
   logic                       w_tag_v;
   logic                       w_tag_l;
   logic                       w_push_req;
   logic                       w_push;
   logic                       w_pop;
   logic                       w_full;

   // Wave tag (valid/last) delayed so it lines up with the aligned vector.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tag_v <= '0;
         r_tag_l <= '0;
      end else begin
         r_tag_v[0] <= in_valid;
         r_tag_l[0] <= in_last;
         for (int k = 1; k < DLY; k++) begin
            r_tag_v[k] <= r_tag_v[k-1];
            r_tag_l[k] <= r_tag_l[k-1];
         end
      end
   end

   assign w_tag_v = r_tag_v[DLY-1];
   assign w_tag_l = r_tag_l[DLY-1];

   // Row i arrives i cycles late, so it needs NUM_PE_ROWS-1-i delay stages.
   for (genvar i = 0; i < NUM_PE_ROWS; i++) begin : g_row
      localparam int D = NUM_PE_ROWS - 1 - i;
      if (D == 0) begin : g_direct
         assign w_aligned[i*PSB +: PSB] = result_flat[i*PSB +: PSB];
      end else begin : g_delay
         logic [PSB-1:0] r_dl [D];
         // Per-row deskew shift register.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int k = 0; k < D; k++) r_dl[k] <= '0;
            end else begin
               r_dl[0] <= result_flat[i*PSB +: PSB];
               for (int k = 1; k < D; k++) r_dl[k] <= r_dl[k-1];
            end
         end
         assign w_aligned[i*PSB +: PSB] = r_dl[D-1];
      end
      // Sign-extend the aligned row; a closed group starts from zero.
      assign w_sum[i*ACC_BW +: ACC_BW] =
         (r_open ? r_acc[i*ACC_BW +: ACC_BW] : {ACC_BW{1'b0}}) +
         ACC_BW'($signed(w_aligned[i*PSB +: PSB]));
   end

   // Accumulator keeps running sums of an open group; the last wave goes to the FIFO.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc  <= '0;
         r_open <= 1'b0;
      end else if (w_tag_v) begin
         if (w_tag_l) begin
            r_open <= 1'b0;
         end else begin
            r_acc  <= w_sum;
            r_open <= 1'b1;
         end
      end
   end

   assign w_push_req = w_tag_v & w_tag_l;
   assign w_pop      = out_valid & out_ready;
   assign w_full     = (r_count == CW'(FIFO_DEPTH));
   // A pop in the same cycle frees the slot, so a full FIFO can still accept.
   assign w_push     = w_push_req & (~w_full | w_pop);

   // FIFO storage holds data only; validity comes from the count.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr] <= w_sum;
   end

   // FIFO pointers, occupancy and sticky overrun flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr       <= '0;
         r_rd       <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) r_wr <= r_wr + 1'b1;
         if (w_pop)  r_rd <= r_rd + 1'b1;
         if (w_push && !w_pop)      r_count <= r_count + 1'b1;
         else if (!w_push && w_pop) r_count <= r_count - 1'b1;
         if (w_push_req && w_full && !w_pop) r_overflow <= 1'b1;
      end
   end

   assign out_valid  = (r_count != '0);
   assign out_data   = out_valid ? r_mem[r_rd] : '0;
   assign fifo_count = r_count;
   assign overflow   = r_overflow;
   assign busy       = (|r_tag_v) | r_open | out_valid;

endmodule
`default_nettype wire

// File: tb/tb_systolic_result_drain.sv
`default_nettype none
// ============================================================================
//  Module   : tb_systolic_result_drain
//  Purpose  : Self-checking scoreboard bench for systolic_result_drain.
//  Revision : 1.0  initial release
// ============================================================================
module tb_systolic_result_drain;
   localparam int NR  = 8;
   localparam int PSB = 19;
   localparam int AB  = 32;
   localparam int FD  = 4;
   localparam int OW  = NR * AB;
   localparam int PL  = 64;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              in_valid = 1'b0;
   logic              in_last = 1'b0;
   logic [NR*PSB-1:0] result_flat = '0;
   logic [OW-1:0]     out_data;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [2:0]        fifo_count;
   logic              overflow;
   logic              busy;

   systolic_result_drain #(
      .NUM_PE_ROWS(NR), .PARTIAL_SUM_BW(PSB), .ACC_BW(AB), .FIFO_DEPTH(FD)
   ) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last),
      .result_flat(result_flat), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .fifo_count(fifo_count), .overflow(overflow),
      .busy(busy)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // stimulus plan, indexed by cycle within a run
   logic          plan_v   [PL];
   logic          plan_l   [PL];
   logic          plan_rdy [PL];
   int            plan_row [PL][NR];
   int            cnt_hist [PL];
   int            first_valid;
   logic [OW-1:0] exp_q [$];
   int            model_acc [NR];
   logic          model_open;
   logic          hold_pending;
   logic [OW-1:0] held;

   task automatic check_eq(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic clear_plan(input logic rdy);
      for (int c = 0; c < PL; c++) begin
         plan_v[c] = 1'b0; plan_l[c] = 1'b0; plan_rdy[c] = rdy; cnt_hist[c] = 0;
         for (int i = 0; i < NR; i++) plan_row[c][i] = 0;
      end
   endtask

   // Schedule a wave at cycle t (row i at t+i) and update the reference model.
   // ramp=1 gives row i the value v+i; drop=1 means the finished group is expected lost.
   task automatic add_wave(input int t, input int v, input logic ramp, input logic last, input logic drop);
      logic [OW-1:0] e;
      int s;
      plan_v[t] = 1'b1;
      plan_l[t] = last;
      for (int i = 0; i < NR; i++) begin
         s = ramp ? v + i : v;
         plan_row[t+i][i] = s;
         s = (s << 13) >>> 13;
         s = (model_open ? model_acc[i] : 0) + s;
         e[i*AB +: AB] = s;
         if (!last) model_acc[i] = s;
      end
      if (last) begin
         model_open = 1'b0;
         if (!drop) exp_q.push_back(e);
      end else begin
         model_open = 1'b1;
      end
   endtask

   // Drive the plan one cycle at a time and score whatever the FIFO delivers.
   task automatic run(input int n);
      first_valid = -1;
      for (int c = 0; c < n; c++) begin
         in_valid  = plan_v[c];
         in_last   = plan_l[c];
         out_ready = plan_rdy[c];
         for (int i = 0; i < NR; i++) result_flat[i*PSB +: PSB] = PSB'(plan_row[c][i]);
         cnt_hist[c] = int'(fifo_count);
         if (out_valid && first_valid < 0) first_valid = c;
         if (hold_pending) check_eq("stable", out_data, held);
         hold_pending = out_valid && !out_ready;
         held = out_data;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check_eq("pending_exp", OW'(exp_q.size()), OW'(1));
            else check_eq("data", out_data, exp_q.pop_front());
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      check_eq({tag, "_qempty"}, OW'(exp_q.size()), OW'(0));
      check_eq({tag, "_busy"}, OW'(busy), OW'(0));
   endtask

   task automatic check_reset_outs(input string tag);
      check_eq({tag, "_valid"}, OW'(out_valid), OW'(0));
      check_eq({tag, "_count"}, OW'(fifo_count), OW'(0));
      check_eq({tag, "_ovf"}, OW'(overflow), OW'(0));
      check_eq({tag, "_busy"}, OW'(busy), OW'(0));
      check_eq({tag, "_data"}, out_data, OW'(0));
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
      exp_q.delete();
      model_open = 1'b0;
      for (int i = 0; i < NR; i++) model_acc[i] = 0;
      hold_pending = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      model_open = 1'b0;
      hold_pending = 1'b0;
      for (int i = 0; i < NR; i++) model_acc[i] = 0;

      // reset state, with in_valid asserted to confirm it is ignored
      in_valid = 1'b1; in_last = 1'b1;
      repeat (3) @(posedge clk);
      #1 check_reset_outs("rst");
      do_reset();

      // single group of one: lanes 1..8, visible at cycle 8
      clear_plan(1'b1);
      add_wave(0, 1, 1'b1, 1'b1, 1'b0);
      run(12);
      check_eq("lat_first_valid", OW'(first_valid), OW'(8));
      check_eq("lat_count8", OW'(cnt_hist[8]), OW'(1));
      check_idle("single");

      // group of three (-5,-2,100) then a fresh single group of 7
      clear_plan(1'b1);
      add_wave(0, -5, 1'b0, 1'b0, 1'b0);
      add_wave(1, -2, 1'b0, 1'b0, 1'b0);
      add_wave(2, 100, 1'b0, 1'b1, 1'b0);
      add_wave(3, 7, 1'b0, 1'b1, 1'b0);
      run(16);
      check_idle("grp3");

      // width: 16 waves of max positive 19-bit value
      clear_plan(1'b1);
      for (int w = 0; w < 16; w++) add_wave(w, 262143, 1'b0, (w == 15), 1'b0);
      run(30);
      check_idle("width");

      // overflow: five groups into a four-deep FIFO with no consumer
      clear_plan(1'b0);
      for (int w = 0; w < 5; w++) add_wave(w, w + 1, 1'b0, 1'b1, (w == 4));
      run(14);
      check_eq("ovf_count", OW'(fifo_count), OW'(4));
      check_eq("ovf_flag", OW'(overflow), OW'(1));
      // push and pop in the same cycle while full
      clear_plan(1'b0);
      add_wave(0, 6, 1'b0, 1'b1, 1'b0);
      plan_rdy[7] = 1'b1;
      run(10);
      check_eq("full_pushpop_count", OW'(cnt_hist[8]), OW'(4));
      check_eq("ovf_sticky", OW'(overflow), OW'(1));
      clear_plan(1'b1);
      run(8);
      check_idle("ovf_drain");
      check_eq("ovf_sticky2", OW'(overflow), OW'(1));
      do_reset();

      // backpressure: two entries, ready toggled 1,0,1
      clear_plan(1'b0);
      add_wave(0, 10, 1'b0, 1'b1, 1'b0);
      add_wave(1, 20, 1'b1, 1'b1, 1'b0);
      plan_rdy[10] = 1'b1; plan_rdy[11] = 1'b0; plan_rdy[12] = 1'b1;
      run(14);
      check_eq("bp_cnt10", OW'(cnt_hist[10]), OW'(2));
      check_eq("bp_cnt11", OW'(cnt_hist[11]), OW'(1));
      check_eq("bp_cnt12", OW'(cnt_hist[12]), OW'(1));
      check_eq("bp_cnt13", OW'(cnt_hist[13]), OW'(0));
      check_idle("bp");

      // reset in cycle 4 of a three-wave group
      clear_plan(1'b1);
      add_wave(0, 9, 1'b0, 1'b0, 1'b0);
      add_wave(1, 9, 1'b0, 1'b0, 1'b0);
      add_wave(2, 9, 1'b0, 1'b1, 1'b0);
      run(4);
      rst = 1'b1;
      #1 check_reset_outs("midrst");
      do_reset();
      clear_plan(1'b1);
      add_wave(0, 3, 1'b0, 1'b1, 1'b0);
      run(12);
      check_idle("post_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // hard time limit so the bench always terminates
   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end
endmodule
`default_nettype wire
